// File: rtl/add40_byte_seq_pkg.sv
// Shared widths, beat counter sizing and sequencer state encoding for the
// byte-serial 40-bit adder front/back end.
package add40_byte_seq_pkg;
  localparam int DATA_W = 40;
  localparam int BEAT_W = 8;
  localparam int NBEATS = DATA_W / BEAT_W;
  localparam int CNT_W  = $clog2(NBEATS);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    UNLOAD
  } state_t;
endpackage

// File: rtl/add40_byte_seq_rca40.sv
// 40-bit combinational ripple-carry adder core: {Cout,S} = A + B + Cin.
module rca40
  import add40_byte_seq_pkg::*;
(
  output logic [DATA_W-1:0] S,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              Cout,
  input  logic              Cin
);

  always_comb begin
    logic c;
    c = Cin;
    S = '0;
    for (int i = 0; i < DATA_W; i++) begin
      S[i] = A[i] ^ B[i] ^ c;
      c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end

endmodule

// File: rtl/add40_byte_seq.sv
// Byte-serial wrapper around rca40: gathers A/B LSB byte first, adds in one
// CALC cycle, then streams the sum back LSB byte first with carry on the last beat.
module add40_byte_seq
  import add40_byte_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_a,
  input  logic [BEAT_W-1:0] in_b,
  input  logic              in_cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout
);

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               cnt;
  logic [NBEATS-1:0][BEAT_W-1:0]  a_reg, b_reg, sum_reg;
  logic                           cin_reg, cout_reg;
  logic [DATA_W-1:0]              s_w;
  logic                           cout_w;
  logic                           in_fire, out_fire, cnt_last;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign cnt_last = (cnt == LAST_BEAT);

  rca40 u_rca40 (
    .S   (s_w),
    .A   (a_reg),
    .B   (b_reg),
    .Cout(cout_w),
    .Cin (cin_reg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && cnt_last)  state_nxt = CALC;
      CALC:                              state_nxt = UNLOAD;
      UNLOAD:  if (out_fire && cnt_last) state_nxt = LOAD;
      default:                           state_nxt = LOAD;
    endcase
  end

  // in_ready is masked by rst so nothing is accepted while reset is held
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_sum   = '0;
    out_last  = 1'b0;
    out_cout  = 1'b0;
    case (state)
      LOAD:   in_ready = ~rst;
      UNLOAD: begin
        out_valid = 1'b1;
        out_sum   = sum_reg[cnt];
        out_last  = cnt_last;
        out_cout  = cout_reg & cnt_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      cin_reg  <= 1'b0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      if (in_fire || out_fire)
        cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
      if (in_fire) begin
        a_reg[cnt] <= in_a;
        b_reg[cnt] <= in_b;
        if (cnt == '0) cin_reg <= in_cin;
      end
      if (state == CALC) begin
        sum_reg  <= s_w;
        cout_reg <= cout_w;
      end
    end
  end

endmodule

// File: tb/tb_add40_byte_seq.sv
// Directed bench for add40_byte_seq: expected result beats go into a queue when
// an operation is issued; a negedge monitor pops and compares on every output transfer.
module tb_add40_byte_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_cin;
  logic [7:0] in_a, in_b;
  logic       out_valid, out_ready, out_last, out_cout;
  logic [7:0] out_sum;

  typedef struct packed {
    logic [7:0] sum;
    logic       last;
    logic       cout;
  } beat_t;

  beat_t q[$];
  beat_t e;
  int total = 0;
  int bad = 0;
  int beats_seen = 0;

  add40_byte_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_last (out_last),
    .out_cout (out_cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("in_ready_low_in_unload", {63'd0, in_ready}, 64'd0);
      if (out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got sum=%h last=%b with empty queue", out_sum, out_last);
        end else begin
          e = q.pop_front();
          chk("out_beat{sum,last,cout}", {54'd0, out_sum, out_last, out_cout}, {54'd0, e});
        end
        beats_seen++;
      end
    end
  end

  // r holds the hand-computed 41-bit {cout,sum}
  task automatic expect_op(input logic [40:0] r, input int n);
    for (int k = 0; k < n; k++)
      q.push_back({r[8*k +: 8], k == 4, (k == 4) & r[40]});
  endtask

  task automatic put_beat(input logic [7:0] a, input logic [7:0] b, input logic c, input int gap);
    int n;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_accept_within_budget", {63'd0, n < 50}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 8'h00;
    in_b     = 8'h00;
    in_cin   = 1'b0;
  endtask

  task automatic send_op(input logic [39:0] a, input logic [39:0] b, input logic cin,
                         input logic cin_later, input int max_gap, input int nbeats);
    for (int k = 0; k < nbeats; k++)
      put_beat(a[8*k +: 8], b[8*k +: 8], (k == 0) ? cin : cin_later,
               (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_within_budget", {63'd0, n < 200}, 64'd1);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats_seen != target && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_beat_index", {63'd0, n < 100}, 64'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_out_sum"},   {56'd0, out_sum},   64'd0);
    chk({tag, "_out_last"},  {63'd0, out_last},  64'd0);
    chk({tag, "_out_cout"},  {63'd0, out_cout},  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_cin    = 1'b0;
    out_ready = 1'b1;

    #3;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
    chk_idle_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("load_in_ready", {63'd0, in_ready}, 64'd1);

    // 1 + 1, no stalls, with latency check
    expect_op(41'h000_0000_0002, 5);
    send_op(40'h00_0000_0001, 40'h00_0000_0001, 1'b0, 1'b0, 0, 5);
    @(negedge clk);
    chk("calc_cycle_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
    drain();

    // full 40-bit ripple from cin
    expect_op(41'h100_0000_0000, 5);
    send_op(40'hFF_FFFF_FFFF, 40'h00_0000_0000, 1'b1, 1'b0, 0, 5);
    drain();

    // cin only taken from beat 0
    expect_op(41'h100_0000_0001, 5);
    send_op(40'h80_0000_0000, 40'h80_0000_0000, 1'b1, 1'b0, 0, 5);
    drain();

    // input gaps plus a 3-cycle output stall on beat 2
    base = beats_seen;
    expect_op(41'h000_2143_6587_A9 & 41'h0FF_FFFF_FFFF, 5);
    send_op(40'h12_3456_789A, 40'h0F_0F0F_0F0F, 1'b0, 1'b0, 2, 5);
    wait_beats(base + 2);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_out_sum",   {56'd0, out_sum},   64'h65);
      chk("stall_out_last",  {63'd0, out_last},  64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // reset during load, partial operands must be discarded
    send_op(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1, 1'b1, 0, 3);
    rst = 1'b1;
    #1;
    chk("midload_rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk_idle_outputs("midload_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_op(41'h000_0000_0100, 5);
    send_op(40'h00_0000_00FF, 40'h00_0000_0001, 1'b0, 1'b0, 0, 5);
    drain();

    // reset during unload after two beats, then a fresh operation
    base = beats_seen;
    expect_op(41'h000_0000_0003, 2);
    send_op(40'h00_0000_0001, 40'h00_0000_0002, 1'b0, 1'b0, 0, 5);
    wait_beats(base + 2);
    rst = 1'b1;
    #1;
    chk_idle_outputs("midunload_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midunload_rst_queue_empty", 64'(q.size()), 64'd0);
    expect_op(41'h0FF_FFFF_FFFF, 5);
    send_op(40'hAA_AAAA_AAAA, 40'h55_5555_5555, 1'b0, 1'b0, 0, 5);
    drain();

    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
